// File: rtl/otter_pkg.sv
// ============================================================================
// Module  : otter_pkg
// Brief   : Shared control encodings and opcode constants for the OTTER decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package otter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_UIMM = 2'd1
    } alu_srca_t;

    typedef enum logic [2:0] {
        SRCB_RS2  = 3'd0,
        SRCB_IIMM = 3'd1,
        SRCB_SIMM = 3'd2,
        SRCB_PC   = 3'd3
    } alu_srcb_t;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_TRAP   = 3'd4
    } pc_source_t;

    typedef enum logic [1:0] {
        WR_PC4 = 2'd0,
        WR_MEM = 2'd2,
        WR_ALU = 2'd3
    } rf_wr_sel_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        alu_fun_t   alu_fun;
        alu_srca_t  alu_srca;
        alu_srcb_t  alu_srcb;
        pc_source_t pc_source;
        rf_wr_sel_t rf_wr_sel;
        logic       reg_we;
        logic       mem_we;
        logic       mem_rden;
        logic [1:0] mem_size;
        logic       mem_sign;
        logic       illegal;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/otter_skid_buf.sv
// ============================================================================
// Module  : otter_skid_buf
// Brief   : Small FIFO output buffer with flush; ready stays high when full if the head drains.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_skid_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full buffer still accepts when its head leaves on the same edge.
    assign w_full      = (count_q == CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign in_ready_o  = ~w_full | out_ready_i;
    assign w_pop       = out_valid_o & out_ready_i & ~flush_i;
    assign w_push      = in_valid_i & in_ready_o & ~flush_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (w_pop && !w_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/otter_decode_stage.sv
// ============================================================================
// Module  : otter_decode_stage
// Brief   : RV32I control decode with branch resolution, registered through a skid buffer.
//           Optional build macro OTTER_DECODE_ILLEGAL_EN enables illegal-encoding detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_decode_stage
    import otter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     ir_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            int_taken_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [3:0]      alu_fun_o,
    output logic [1:0]      alu_srca_o,
    output logic [2:0]      alu_srcb_o,
    output logic [2:0]      pc_source_o,
    output logic [1:0]      rf_wr_sel_o,
    output logic            reg_we_o,
    output logic            mem_we_o,
    output logic            mem_rden_o,
    output logic [1:0]      mem_size_o,
    output logic            mem_sign_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            illegal_o
);

    localparam int PAY_W = $bits(ctrl_t) + XLEN;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl;
    ctrl_t            w_out_ctrl;
    logic             w_unknown;
    logic             w_bad_f7;
    logic             w_taken;
    logic             w_nop;
    logic             w_illegal;
    logic             w_unused_bits;
    logic [PAY_W-1:0] w_out_data;

    assign w_opcode      = ir_i[6:0];
    assign w_funct3      = ir_i[14:12];
    assign w_bad_f7      = ((w_opcode == OP_REG) || ((w_opcode == OP_IMM) && (w_funct3[1:0] == 2'b01)))
                           && !((ir_i[31:25] == 7'b0000000) || (ir_i[31:25] == 7'b0100000));
    assign w_unused_bits = ^{w_bad_f7, ir_i[11:7], ir_i[24:15]};

    always_comb begin
        w_dec     = '0;
        w_unknown = 1'b0;
        w_taken   = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_dec.alu_fun   = ALU_LUI;
                w_dec.alu_srca  = SRCA_UIMM;
                w_dec.rf_wr_sel = WR_ALU;
                w_dec.reg_we    = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.alu_srca  = SRCA_UIMM;
                w_dec.alu_srcb  = SRCB_PC;
                w_dec.rf_wr_sel = WR_ALU;
                w_dec.reg_we    = 1'b1;
            end
            OP_JAL: begin
                w_dec.pc_source = PC_JAL;
                w_dec.reg_we    = 1'b1;
            end
            OP_JALR: begin
                w_unknown       = (w_funct3 != 3'b000);
                w_dec.pc_source = PC_JALR;
                w_dec.reg_we    = 1'b1;
            end
            OP_BRANCH: begin
                case (w_funct3)
                    3'b000:  w_taken = (rs1_data_i == rs2_data_i);
                    3'b001:  w_taken = (rs1_data_i != rs2_data_i);
                    3'b100:  w_taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
                    3'b101:  w_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
                    3'b110:  w_taken = (rs1_data_i <  rs2_data_i);
                    3'b111:  w_taken = (rs1_data_i >= rs2_data_i);
                    default: w_unknown = 1'b1;
                endcase
                w_dec.pc_source = w_taken ? PC_BRANCH : PC_PLUS4;
            end
            OP_LOAD: begin
                w_unknown       = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
                w_dec.alu_srcb  = SRCB_IIMM;
                w_dec.rf_wr_sel = WR_MEM;
                w_dec.reg_we    = 1'b1;
                w_dec.mem_rden  = 1'b1;
                w_dec.mem_size  = w_funct3[1:0];
                w_dec.mem_sign  = ~w_funct3[2];
            end
            OP_STORE: begin
                w_unknown      = w_funct3[2] || (w_funct3[1:0] == 2'b11);
                w_dec.alu_srcb = SRCB_SIMM;
                w_dec.mem_we   = 1'b1;
                w_dec.mem_size = w_funct3[1:0];
                w_dec.mem_sign = ~w_funct3[2];
            end
            OP_IMM: begin
                w_dec.alu_fun   = alu_fun_t'({(w_funct3 == 3'b101) & ir_i[30], w_funct3});
                w_dec.alu_srcb  = SRCB_IIMM;
                w_dec.rf_wr_sel = WR_ALU;
                w_dec.reg_we    = 1'b1;
            end
            OP_REG: begin
                w_dec.alu_fun   = alu_fun_t'({((w_funct3 == 3'b000) || (w_funct3 == 3'b101)) & ir_i[30],
                                              w_funct3});
                w_dec.rf_wr_sel = WR_ALU;
                w_dec.reg_we    = 1'b1;
            end
            default: w_unknown = 1'b1;
        endcase
    end

`ifdef OTTER_DECODE_ILLEGAL_EN
    assign w_nop     = w_unknown | w_bad_f7;
    assign w_illegal = w_nop;
`else
    assign w_nop     = w_unknown;
    assign w_illegal = 1'b0;
`endif

    // An interrupt turns the entry into a trap redirect with no side effects.
    always_comb begin
        if (w_nop) w_ctrl = '0;
        else       w_ctrl = w_dec;
        w_ctrl.illegal = w_illegal;
        if (int_taken_i) begin
            w_ctrl.pc_source = PC_TRAP;
            w_ctrl.reg_we    = 1'b0;
            w_ctrl.mem_we    = 1'b0;
            w_ctrl.mem_rden  = 1'b0;
        end
    end

    otter_skid_buf #(
        .WIDTH (PAY_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   ({w_ctrl, pc_i}),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (w_out_data)
    );

    assign w_out_ctrl  = ctrl_t'(w_out_data[PAY_W-1:XLEN]);
    assign out_pc_o    = w_out_data[XLEN-1:0];
    assign alu_fun_o   = w_out_ctrl.alu_fun;
    assign alu_srca_o  = w_out_ctrl.alu_srca;
    assign alu_srcb_o  = w_out_ctrl.alu_srcb;
    assign pc_source_o = w_out_ctrl.pc_source;
    assign rf_wr_sel_o = w_out_ctrl.rf_wr_sel;
    assign reg_we_o    = w_out_ctrl.reg_we;
    assign mem_we_o    = w_out_ctrl.mem_we;
    assign mem_rden_o  = w_out_ctrl.mem_rden;
    assign mem_size_o  = w_out_ctrl.mem_size;
    assign mem_sign_o  = w_out_ctrl.mem_sign;
    assign illegal_o   = w_out_ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_otter_decode_stage.sv
// ============================================================================
// Module  : tb_otter_decode_stage
// Brief   : Directed plus randomized bench for otter_decode_stage (XLEN=64, SKID_DEPTH=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_otter_decode_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    typedef logic [21+XLEN-1:0] ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, int_taken, flush, out_valid, out_ready;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc, rs1, rs2, out_pc;
    logic [3:0]      alu_fun;
    logic [1:0]      alu_srca, rf_wr_sel, mem_size;
    logic [2:0]      alu_srcb, pc_source;
    logic            reg_we, mem_we, mem_rden, mem_sign, illegal;

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    ent_t hold;

    always #5 clk = ~clk;

    otter_decode_stage #(.XLEN(XLEN), .SKID_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ir_i(ir), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .int_taken_i(int_taken), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .alu_fun_o(alu_fun), .alu_srca_o(alu_srca),
        .alu_srcb_o(alu_srcb), .pc_source_o(pc_source), .rf_wr_sel_o(rf_wr_sel),
        .reg_we_o(reg_we), .mem_we_o(mem_we), .mem_rden_o(mem_rden),
        .mem_size_o(mem_size), .mem_sign_o(mem_sign), .out_pc_o(out_pc),
        .illegal_o(illegal)
    );

    function automatic ent_t obs();
        return {alu_fun, alu_srca, alu_srcb, pc_source, rf_wr_sel, reg_we, mem_we,
                mem_rden, mem_size, mem_sign, illegal, out_pc};
    endfunction

    function automatic logic [3:0] alu_code(input string m);
        case (m)
            "sll": return 4'b0001;  "slt": return 4'b0010;  "sltu": return 4'b0011;
            "xor": return 4'b0100;  "srl": return 4'b0101;  "sra":  return 4'b1101;
            "or":  return 4'b0110;  "and": return 4'b0111;  "sub":  return 4'b1000;
            "lui": return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Reference decode: name the instruction, then read its controls from the rules.
    function automatic ent_t ref_dec(input logic [31:0] i, input logic [XLEN-1:0] p,
                                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic intr);
        string      names[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        int         f3 = int'(i[14:12]);
        string      m = "";
        logic [1:0] sa = 0, ws = 0, sz = 0;
        logic [2:0] sb = 0, ps = 0;
        logic       we = 0, mw = 0, mr = 0, ms = 0, ok = 1, need_f7 = 0, bad, ill, t = 0;
        logic       f7ok = (i[31:25] == 7'h00) || (i[31:25] == 7'h20);
        case (i[6:0])
            7'h37: begin m = "lui"; sa = 1; ws = 3; we = 1; end
            7'h17: begin sa = 1; sb = 3; ws = 3; we = 1; end
            7'h6F: begin ps = 3; we = 1; end
            7'h67: begin ok = (f3 == 0); ps = 1; we = 1; end
            7'h63: begin
                case (f3)
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = !($signed(a) < $signed(b));
                    6: t = (a < b);
                    7: t = !(a < b);
                    default: ok = 0;
                endcase
                ps = t ? 3'd2 : 3'd0;
            end
            7'h03: begin ok = (f3 inside {0, 1, 2, 4, 5}); sb = 1; ws = 2; we = 1; mr = 1;
                         sz = i[13:12]; ms = !i[14]; end
            7'h23: begin ok = (f3 inside {0, 1, 2}); sb = 2; mw = 1; sz = i[13:12]; ms = !i[14]; end
            7'h13: begin
                m = names[f3];
                if (m == "srl" && i[30]) m = "sra";
                need_f7 = (f3 == 1 || f3 == 5);
                sb = 1; ws = 3; we = 1;
            end
            7'h33: begin
                m = names[f3];
                if (i[30] && m == "add") m = "sub";
                if (i[30] && m == "srl") m = "sra";
                need_f7 = 1; ws = 3; we = 1;
            end
            default: ok = 0;
        endcase
`ifdef OTTER_DECODE_ILLEGAL_EN
        bad = !ok || (need_f7 && !f7ok);
        ill = bad;
`else
        bad = !ok;
        ill = 1'b0;
`endif
        if (bad) begin
            m = ""; sa = 0; sb = 0; ps = 0; ws = 0; we = 0; mw = 0; mr = 0; sz = 0; ms = 0;
        end
        if (intr) begin
            ps = 4; we = 0; mw = 0; mr = 0;
        end
        return {alu_code(m), sa, sb, ps, ws, we, mw, mr, sz, ms, ill, p};
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Inputs are already driven (just after a falling edge); check, model the edge, advance.
    task automatic step();
        logic rdy;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        rdy = (q.size() < DEPTH) || out_ready;
        chk("in_ready", in_ready, rdy);
        if (q.size() != 0) chk("payload", obs(), q[0]);
        if (flush) q.delete();
        else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(ref_dec(ir, pc, rs1, rs2, int_taken));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic rdy);
        in_valid  = v;
        ir        = i;
        pc        = {$urandom, $urandom};
        out_ready = rdy;
        int_taken = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                 7'h13, 7'h33, 7'h7F, 7'h73, 7'h0F};
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 12);
        if (k == 12) return r;
        r[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        rs1 = '0;
        rs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", obs(), '0);
        rst_n = 1'b1;

        // sub x0, x1, x2
        drive(1'b1, 32'h40208033, 1'b1);
        step();
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_alu_fun", alu_fun, 4'b1000);
        chk("sub_rf_wr_sel", rf_wr_sel, 2'd3);
        chk("sub_reg_we", reg_we, 1'b1);

        // branches at full 64-bit width
        drive(1'b1, 32'h00208063, 1'b1); rs1 = 64'd5; rs2 = 64'd5;
        step();
        chk("beq_taken", pc_source, 3'd2);
        drive(1'b1, 32'h0020C063, 1'b1); rs1 = '1; rs2 = 64'd1;
        step();
        chk("blt_taken", pc_source, 3'd2);
        drive(1'b1, 32'h0020E063, 1'b1);
        step();
        chk("bltu_not_taken", pc_source, 3'd0);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // backpressure: two accepts fill the buffer, head holds steady
        drive(1'b1, 32'h00A00093, 1'b0);
        step();
        hold = obs();
        drive(1'b1, 32'h0020F1B3, 1'b0);
        step();
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_stable1", obs(), hold);
        drive(1'b1, 32'h00209213, 1'b0);
        step();
        chk("bp_stable2", obs(), hold);
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();
        step();

        // sw under interrupt
        drive(1'b1, 32'h0020A023, 1'b1); int_taken = 1'b1;
        step();
        chk("sw_int_pcsrc", pc_source, 3'd4);
        chk("sw_int_mem_we", mem_we, 1'b0);

        // flush with two entries held
        drive(1'b1, 32'h00112023, 1'b0);
        step();
        step();
        drive(1'b1, 32'h00000013, 1'b0); flush = 1'b1;
        step();
        chk("flush_valid", out_valid, 1'b0);

        // all-ones word
        drive(1'b1, 32'hFFFFFFFF, 1'b1);
        step();
`ifdef OTTER_DECODE_ILLEGAL_EN
        chk("illegal_flag", illegal, 1'b1);
`else
        chk("illegal_flag", illegal, 1'b0);
`endif
        chk("illegal_enables", {reg_we, mem_we, mem_rden, pc_source}, 6'd0);

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rand_ir(), $urandom_range(0, 2) != 0);
            int_taken = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            rs1       = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rs2 = rs1;
                1: rs2 = ~rs1;
                2: rs2 = rs1 ^ (64'd1 << $urandom_range(0, 63));
                default: rs2 = {$urandom, $urandom};
            endcase
            step();
        end

        // asynchronous reset mid-stream
        drive(1'b1, 32'h00500113, 1'b0);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_outputs", obs(), '0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
